// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MTHI/MTLO complete in one cycle.
// State advances on the falling clock edge, in step with the pipeline registers.
module ex_muldiv_unit #(
   parameter int WIDTH    = 32,
   parameter int CNT_BITS = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             debugEnable,
   input  logic             debugReset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   input  logic             mfRead,
   output logic [WIDTH-1:0] hiOut,
   output logic [WIDTH-1:0] loOut,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             divByZero
);

   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

   state_t                stateReg, stateNext;
   logic [CNT_BITS-1:0]   counterReg, counterNext;
   logic [2*WIDTH-1:0]    accReg, accNext;
   logic [WIDTH-1:0]      operandReg, operandNext;
   logic                  signAReg, signANext;
   logic                  signBReg, signBNext;
   logic                  isDivReg, isDivNext;
   logic [WIDTH-1:0]      hiReg, hiNext;
   logic [WIDTH-1:0]      loReg, loNext;
   logic                  doneReg, doneNext;
   logic                  divByZeroReg, divByZeroNext;

   logic                  opSigned;
   logic                  negA, negB;
   logic [WIDTH-1:0]      magA, magB;
   logic [WIDTH:0]        mulSum;
   logic [WIDTH:0]        divShift, divDiff;
   logic [2*WIDTH-1:0]    mulAccNext, divAccNext;
   logic [2*WIDTH-1:0]    signedProduct;
   logic [WIDTH-1:0]      quotient, remainder;

   assign opSigned = ~op[0];
   assign negA     = opSigned & operandA[WIDTH-1];
   assign negB     = opSigned & operandB[WIDTH-1];
   assign magA     = negA ? -operandA : operandA;
   assign magB     = negB ? -operandB : operandB;

   // Multiply: accumulator is {partial product, remaining multiplier bits}.
   assign mulSum     = {1'b0, accReg[2*WIDTH-1:WIDTH]} + (accReg[0] ? {1'b0, operandReg} : '0);
   assign mulAccNext = {mulSum, accReg[WIDTH-1:1]};

   // Divide: accumulator is {partial remainder, dividend bits shifting into quotient}.
   assign divShift   = accReg[2*WIDTH-1:WIDTH-1];
   assign divDiff    = divShift - {1'b0, operandReg};
   assign divAccNext = divDiff[WIDTH] ? {divShift[WIDTH-1:0], accReg[WIDTH-2:0], 1'b0}
                                      : {divDiff[WIDTH-1:0],  accReg[WIDTH-2:0], 1'b1};

   assign signedProduct = (signAReg ^ signBReg) ? -accReg : accReg;
   assign quotient      = (signAReg ^ signBReg) ? -accReg[WIDTH-1:0] : accReg[WIDTH-1:0];
   assign remainder     = signAReg ? -accReg[2*WIDTH-1:WIDTH] : accReg[2*WIDTH-1:WIDTH];

   always_comb begin
      stateNext     = stateReg;
      counterNext   = counterReg;
      accNext       = accReg;
      operandNext   = operandReg;
      signANext     = signAReg;
      signBNext     = signBReg;
      isDivNext     = isDivReg;
      hiNext        = hiReg;
      loNext        = loReg;
      doneNext      = doneReg;
      divByZeroNext = divByZeroReg;
      if (debugEnable) begin
         doneNext = 1'b0;
         case (stateReg)
            IDLE: begin
               if (start) begin
                  if (op == OP_MTHI) begin
                     hiNext = operandA;
                  end else if (op == OP_MTLO) begin
                     loNext = operandA;
                  end else if (op[2] == 1'b0) begin
                     signANext     = negA;
                     signBNext     = negB;
                     isDivNext     = op[1];
                     counterNext   = '0;
                     divByZeroNext = op[1] & (operandB == '0);
                     stateNext     = RUN;
                     if (!op[1]) begin
                        operandNext = magA;
                        accNext     = {{WIDTH{1'b0}}, magB};
                     end else begin
                        operandNext = magB;
                        if (operandB == '0) begin
                           // Remainder = dividend, quotient = all ones; no iterations needed.
                           accNext   = {magA, {WIDTH{1'b1}}};
                           stateNext = SIGN;
                        end else begin
                           accNext = {{WIDTH{1'b0}}, magA};
                        end
                     end
                  end
               end
            end
            RUN: begin
               accNext = isDivReg ? divAccNext : mulAccNext;
               if (counterReg == CNT_BITS'(WIDTH - 1)) begin
                  stateNext = SIGN;
               end else begin
                  counterNext = counterReg + CNT_BITS'(1);
               end
            end
            SIGN: begin
               if (!isDivReg) begin
                  {hiNext, loNext} = signedProduct;
               end else begin
                  hiNext = remainder;
                  loNext = divByZeroReg ? accReg[WIDTH-1:0] : quotient;
               end
               doneNext  = 1'b1;
               stateNext = IDLE;
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(negedge clock) begin
      if (reset || debugReset) begin
         stateReg     <= IDLE;
         counterReg   <= '0;
         accReg       <= '0;
         operandReg   <= '0;
         signAReg     <= 1'b0;
         signBReg     <= 1'b0;
         isDivReg     <= 1'b0;
         hiReg        <= '0;
         loReg        <= '0;
         doneReg      <= 1'b0;
         divByZeroReg <= 1'b0;
      end else begin
         stateReg     <= stateNext;
         counterReg   <= counterNext;
         accReg       <= accNext;
         operandReg   <= operandNext;
         signAReg     <= signANext;
         signBReg     <= signBNext;
         isDivReg     <= isDivNext;
         hiReg        <= hiNext;
         loReg        <= loNext;
         doneReg      <= doneNext;
         divByZeroReg <= divByZeroNext;
      end
   end

   assign hiOut     = hiReg;
   assign loOut     = loReg;
   assign busy      = (stateReg != IDLE);
   assign stall     = busy & (start | mfRead);
   assign done      = doneReg;
   assign divByZero = divByZeroReg;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, fed by the operand and control outputs of the ID/EX pipeline register.
- Owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU in 33 cycles and MTHI/MTLO in one.
- Asserts a stall toward the hazard logic so that IF/ID and ID/EX freeze while a dependent instruction waits.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_BITS, 6, iteration counter width; must hold WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the falling edge, matching the pipeline registers.
- reset  input  1  synchronous, active-high; clears all state.
- debugEnable  input  1  pipeline step enable; when 0, all state holds.
- debugReset  input  1  synchronous clear, same effect as reset.
- start  input  1  muldiv/MT instruction present in EX this cycle.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 ignored.
- operandA  input  WIDTH  rs value after forwarding.
- operandB  input  WIDTH  rt value after forwarding.
- mfRead  input  1  MFHI/MFLO present in ID stage.
- hiOut  output  WIDTH  HI register.
- loOut  output  WIDTH  LO register.
- busy  output  1  operation in progress.
- stall  output  1  freeze request to hazard unit.
- done  output  1  one-cycle pulse when HI/LO are written by a mul/div.
- divByZero  output  1  sticky flag, set by DIV/DIVU with operandB=0.

Behaviour:
- Reset/debugReset: highest priority, independent of debugEnable. On reset:
  - state=IDLE, counter=0.
  - hiOut=0, loOut=0.
  - busy=0, done=0, divByZero=0.
  - Aborts any operation in flight; no partial result is written.
- debugEnable=0: state, counter, datapath registers and outputs hold. done stays at its current value. Latency counts enabled edges only.
- FSM states: IDLE, RUN, SIGN.
- IDLE, start=1, op=MTHI/MTLO: hiOut or loOut takes operandA at that edge. No busy, no done.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU:
  - Latch operand magnitudes (signed ops take two's-complement absolute value; unsigned ops take raw values).
  - Latch the sign bits and the op.
  - Clear divByZero.
  - Counter=0, go to RUN.
- DIV/DIVU with operandB=0: go directly to SIGN, skipping RUN, and set divByZero. SIGN then writes HI=operandA (as latched) and LO=all ones.
- RUN, multiply: radix-2 shift-add on a 2*WIDTH accumulator, one bit per cycle.
- RUN, divide: restoring division, one quotient bit per cycle.
- RUN exit: after WIDTH iterations (counter reaches WIDTH-1), go to SIGN.
- SIGN: apply sign correction, write HI/LO, return to IDLE. done=1 for the next cycle.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - HI=product[63:32] or remainder; LO=product[31:0] or quotient.
- Latency: start edge E0, SIGN at E33, so busy=1 from after E0 through E33.
- busy=1 in RUN and SIGN; HI/LO keep their old values until the SIGN edge.
- stall = busy AND (start OR mfRead). Combinational.
  - A second mul/div, MT, or MF request during busy stalls.
  - start while busy is ignored by the FSM; the held instruction is re-presented.
- Results are WIDTH-bit with wrap. Signed most-negative operands are handled via the latched magnitude: 0x80000000 has magnitude 2^31.
- start with op 6/7: no effect.

Test Plan:
- MULTU A=0xFFFFFFFF B=2, debugEnable=1 → busy 33 cycles; done pulse; HI=0x00000001, LO=0xFFFFFFFE.
- MULT A=-3 B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV A=-7 B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=0x1234 B=0 → SIGN the cycle after start; HI=0x00001234, LO=0xFFFFFFFF; divByZero=1. It stays 1 until the next mul/div start clears it.
- MULTU 5*6, then mfRead=1 from cycle 2 → stall=1 through the last busy cycle, 0 after done. MTLO 0xAA in IDLE → loOut=0xAA next edge, busy never rises.
- DIV 100/7 with debugEnable low for 5 cycles mid-RUN → busy lasts 38 cycles; LO=14, HI=2.
- MULT in progress, reset pulsed at cycle 10 → next cycle all outputs 0, state IDLE, no done pulse. Repeat with debugReset: same result.
